stage_ctrl: RTL
===============

# stage_ctrl

Parametrised multi-lane start/finish controller for compute stages. It sits between the source receive logic, a bank of `LANES` compute lanes and a single shared destination buffer. Each lane keeps a bounded count of finished-but-unsent results, with zero-latency bypass when the destination is ready. Completed results are released to the destination one per cycle through a round-robin arbiter, and new starts on a lane are back-pressured when its pending count is full.

## Interface
Parameters:
- `LANES`, 4: number of compute lanes, 1..16.
- `DEPTH`, 4: maximum pending finishes held per lane, 1..15.

Ports:
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `run` in 1: stage enable; low acts as a synchronous flush.
- `src_v` in LANES: per-lane pulse meaning the source batch for that lane has been received.
- `src_rdy` out LANES: lane can accept a new start; combinational, `cnt[i] != DEPTH`.
- `s_init` out LANES: registered one-cycle start pulse per lane.
- `s_fin` in LANES: per-lane pulse meaning the lane's result is fully written.
- `dst_ready` in 1: destination can take one finish this cycle.
- `s_fin_in` out LANES: one-hot release of a finish to the destination; combinational.
- `s_fin_id` out $clog2(LANES) (min 1): index of the granted lane; 0 when no grant.
- `ovf` out 1: sticky overflow error.
- `stall_cnt` out 32: count of back-pressure cycles; tied to 0 unless `STAGE_CTRL_PERF_EN` is defined.

## Operation
- Per lane `i`, counter `cnt[i]` runs 0..DEPTH.
- Request: `req[i] = run & (s_fin[i] | cnt[i] != 0)`.
- Grant: when `dst_ready` is high, exactly one requesting lane is granted, `s_fin_in[i] = 1`.
  - Search starts at lane `ptr+1`, wraps modulo LANES, and takes the first requester.
  - With no requester, or `dst_ready` low, `s_fin_in = 0`.
- `ptr` loads the granted index on every grant and holds otherwise.
- Counter update: `cnt[i] <= cnt[i] + s_fin[i] - s_fin_in[i]`.
  - `s_fin` and grant in the same cycle: count unchanged. At `cnt == 0` this is the pure bypass case.
  - `cnt == DEPTH`, `s_fin` high, no grant: count saturates at DEPTH and `ovf` is set.
- Start: `s_init[i] <= run & src_v[i] & src_rdy[i]`.
  - `src_v` while `src_rdy` is low is dropped, produces no `s_init`, and is not remembered. Holding off is the source's responsibility.
- `ovf` is sticky and clears only on `rst` or `run` low.
- `run` low: synchronously clears `cnt`, `s_init` and `ovf`, sets `ptr = LANES-1`, and forces `s_fin_in = 0`. Pending finishes are discarded.

## Timing
- Reset values:
  - `s_init = 0`, `cnt = 0`, `ptr = LANES-1` (lane 0 wins first).
  - `ovf = 0`, `stall_cnt = 0`.
  - Derived outputs after reset: `src_rdy = all ones`, `s_fin_in = 0`, `s_fin_id = 0`.
- `s_fin` to `s_fin_in`: 0 cycles when granted immediately. Otherwise the finish waits in `cnt`, with no upper bound while `dst_ready` is low.
- `src_v` to `s_init`: 1 cycle.
- `src_rdy` reflects the current `cnt`. A grant frees space visible in the next cycle, not the same cycle.
- Fairness: a continuously requesting lane is granted within LANES grant cycles.
- `rst` takes priority over `run`. Reset mid-operation drops all pending finishes, with no release pulse.

## Configuration
- `STAGE_CTRL_PERF_EN`.
  - Defined: `stall_cnt` increments on every cycle with `run & |req & ~dst_ready`. It wraps at 2^32 and clears on `rst` or `run` low.
  - Undefined: the counter is not instantiated and `stall_cnt` is constant 0.
- All other behaviour is identical in both builds.

## Structure
- Package `stage_ctrl_pkg`:
  - `MAX_LANES = 16`, `MAX_DEPTH = 15`.
  - Typedef `cnt_t`, 4-bit pending count.
  - Function `lane_w(n)` returning max(1, $clog2(n)).
- Sub-module `rr_arbiter`, parameter `N`:
  - Inputs: `req`, `en` (= `dst_ready`), `ptr`.
  - Outputs: one-hot `gnt` and encoded `gnt_id`.
  - Purely combinational; `ptr` is registered in `stage_ctrl`.

## Test plan
- After reset, `s_fin[0]` pulses with `dst_ready = 1` → same-cycle `s_fin_in = 0001`, `s_fin_id = 0`, `cnt[0]` stays 0.
- `dst_ready = 0`; `s_fin` pulses on lanes 0, 2, 3; then `dst_ready = 1` → grants lane 0, 2, 3 on consecutive cycles, then `s_fin_in = 0`.
- Lanes 1 and 2 pulse `s_fin` 4 times each with `dst_ready` low, then `dst_ready = 1` (LANES = 4, DEPTH = 4):
  - `src_rdy[1]` and `src_rdy[2]` are 0 while full.
  - Release order is 1, 2, 1, 2, 1, 2, 1, 2.
  - `src_rdy[1]` rises the cycle after lane 1's first grant; `src_rdy[2]` rises the cycle after lane 2's first grant.
- Lane 3 at `cnt = 4` gets a 5th `s_fin` with `dst_ready = 0` → `ovf = 1` next cycle and `cnt` stays 4. `ovf` stays high until `run` is dropped.
- `src_v = 0101` with lane 2 full → next cycle `s_init = 0001`.
- `run` low for one cycle mid-traffic with pending counts {2, 1, 0, 3} → all `cnt` = 0 and `ovf` = 0; after `run` returns, the first grant goes to lane 0. With `STAGE_CTRL_PERF_EN` defined, also check that 7 stalled cycles give `stall_cnt = 7`.

Source files
------------

// File: rtl/stage_ctrl_pkg.sv
// stage_ctrl_pkg: shared types, limits and helpers for the stage controller.
//   MAX_LANES / MAX_DEPTH : legal upper bounds for the LANES / DEPTH parameters
//   cnt_t                 : per-lane pending finish count (0..15)
//   lane_w(n)             : width of a lane index for n lanes, never below 1
package stage_ctrl_pkg;

    localparam int unsigned MAX_LANES = 16;
    localparam int unsigned MAX_DEPTH = 15;

    typedef logic [3:0] cnt_t;

    function automatic int unsigned lane_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req    in  N          : request vector
//   en     in  1          : grant enable (destination ready)
//   ptr    in  lane_w(N)  : last granted index; search starts at ptr+1
//   gnt    out N          : one-hot grant, zero when en low or no request
//   gnt_id out lane_w(N)  : encoded grant index, zero when no grant
module rr_arbiter
    import stage_ctrl_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic [lane_w(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [lane_w(N)-1:0] gnt_id
);

    localparam int unsigned W = lane_w(N);

    always_comb begin
        logic         found;
        int unsigned  idx;
        logic [W-1:0] idx_w;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        // Walk ptr+1, ptr+2, ... ptr+N (mod N); first requester wins.
        for (int unsigned k = 1; k <= N; k++) begin
            idx   = (32'(ptr) + k) % N;
            idx_w = W'(idx);
            if (en && !found && req[idx_w]) begin
                found       = 1'b1;
                gnt[idx_w]  = 1'b1;
                gnt_id      = idx_w;
            end
        end
    end

endmodule

// File: rtl/stage_ctrl.sv
// stage_ctrl: multi-lane start/finish controller for compute stages.
// Each lane tracks finished-but-unsent results in a saturating counter; finishes are
// released to a single shared destination one per cycle through a round-robin
// arbiter, with same-cycle bypass when the destination is ready.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   run        : stage enable; low flushes all state synchronously
//   src_v      : per-lane source batch received pulse
//   src_rdy    : per-lane start accept (cnt != DEPTH), combinational
//   s_init     : registered one-cycle start pulse per lane
//   s_fin      : per-lane result written pulse
//   dst_ready  : destination accepts one finish this cycle
//   s_fin_in   : one-hot finish release, combinational
//   s_fin_id   : granted lane index, 0 when no grant
//   ovf        : sticky overflow (finish arrived on a full lane with no grant)
//   stall_cnt  : back-pressure cycle counter
// Build option: define STAGE_CTRL_PERF_EN to instantiate stall_cnt; otherwise it is 0.
module stage_ctrl
    import stage_ctrl_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [LANES-1:0]         src_v,
    output logic [LANES-1:0]         src_rdy,
    output logic [LANES-1:0]         s_init,
    input  logic [LANES-1:0]         s_fin,
    input  logic                     dst_ready,
    output logic [LANES-1:0]         s_fin_in,
    output logic [lane_w(LANES)-1:0] s_fin_id,
    output logic                     ovf,
    output logic [31:0]              stall_cnt
);

    localparam int unsigned   LW      = lane_w(LANES);
    localparam cnt_t          DEPTH_C = cnt_t'(DEPTH);
    localparam logic [LW-1:0] PTR_RST = LW'(LANES - 1);

    if (LANES < 1 || LANES > MAX_LANES || DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_param
        $error("stage_ctrl: LANES or DEPTH out of range");
    end

    cnt_t            cnt_q [LANES];
    cnt_t            cnt_d [LANES];
    logic [LANES-1:0] s_init_q, s_init_d;
    logic [LW-1:0]    ptr_q, ptr_d;
    logic             ovf_q, ovf_d;

    logic [LANES-1:0] req;
    logic [LANES-1:0] gnt;
    logic [LW-1:0]    gnt_id;

    always_comb begin
        req     = '0;
        src_rdy = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            req[i]     = run & (s_fin[i] | (cnt_q[i] != '0));
            src_rdy[i] = (cnt_q[i] != DEPTH_C);
        end
    end

    rr_arbiter #(
        .N (LANES)
    ) u_arb (
        .req    (req),
        .en     (dst_ready),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // req is already gated by run, so no release is possible while flushing.
    assign s_fin_in = gnt;
    assign s_fin_id = gnt_id;
    assign s_init   = s_init_q;
    assign ovf      = ovf_q;

    always_comb begin
        ovf_d    = ovf_q;
        ptr_d    = ptr_q;
        s_init_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (|gnt) begin
            ptr_d = gnt_id;
        end

        for (int unsigned i = 0; i < LANES; i++) begin
            s_init_d[i] = run & src_v[i] & src_rdy[i];
            if (s_fin[i] && !gnt[i]) begin
                if (cnt_q[i] == DEPTH_C) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + cnt_t'(1);
                end
            end else if (!s_fin[i] && gnt[i]) begin
                // A grant without a same-cycle finish implies cnt_q[i] != 0.
                cnt_d[i] = cnt_q[i] - cnt_t'(1);
            end
        end

        if (!run) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                cnt_d[i] = '0;
            end
            s_init_d = '0;
            ovf_d    = 1'b0;
            ptr_d    = PTR_RST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '{default: '0};
            s_init_q <= '0;
            ptr_q    <= PTR_RST;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            s_init_q <= s_init_d;
            ptr_q    <= ptr_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef STAGE_CTRL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            stall_q <= '0;
        end else if (|req && !dst_ready) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
